// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback logic: load extraction, load-wait back-pressure,
// retirement counting and sticky load-fault flag.
module writeback_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InstrValidM,
  input  logic        RegWriteM,
  input  logic        MemToRegM,
  input  logic [2:0]  LoadTypeM,
  input  logic [31:0] ALUOutM,
  input  logic [4:0]  WriteRegM,
  input  logic [31:0] ReadDataM,
  input  logic        ReadValidM,
  input  logic        FlushW,
  output logic        StallM,
  output logic [31:0] ResultW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW,
  output logic [31:0] RetireCountW,
  output logic        ErrorW
);

  localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT) + 1;

  typedef enum logic {S_RUN, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         write_reg_q, write_reg_d;
  logic               reg_write_q, reg_write_d;
  logic [31:0]        retire_cnt_q, retire_cnt_d;
  logic               error_q, error_d;

  logic               load;
  logic               misaligned;
  logic               timeout_hit;
  logic               stall;
  logic               bubble;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_data;

  // Big-endian byte/half selection and extension of the returned word
  always_comb begin
    byte_sel  = ReadDataM[31:24];
    case (ALUOutM[1:0])
      2'd1:    byte_sel = ReadDataM[23:16];
      2'd2:    byte_sel = ReadDataM[15:8];
      2'd3:    byte_sel = ReadDataM[7:0];
      default: byte_sel = ReadDataM[31:24];
    endcase
    half_sel   = ALUOutM[1] ? ReadDataM[15:0] : ReadDataM[31:16];
    load_data  = ReadDataM;
    misaligned = |ALUOutM[1:0];
    case (LoadTypeM)
      3'b001: begin load_data = {{24{byte_sel[7]}}, byte_sel}; misaligned = 1'b0; end
      3'b101: begin load_data = {24'd0, byte_sel};             misaligned = 1'b0; end
      3'b010: begin load_data = {{16{half_sel[15]}}, half_sel}; misaligned = ALUOutM[0]; end
      3'b110: begin load_data = {16'd0, half_sel};              misaligned = ALUOutM[0]; end
      default: begin load_data = ReadDataM; misaligned = |ALUOutM[1:0]; end
    endcase
  end

  assign load        = InstrValidM & MemToRegM & RegWriteM;
  assign timeout_hit = (state_q == S_WAIT) & (wait_cnt_q == CNT_W'(LOAD_TIMEOUT - 1)) & ~ReadValidM;
  // Misaligned loads never wait on memory; stall is forced low while in reset
  assign stall       = rst_n & load & ~misaligned & ~ReadValidM & ~FlushW & ~timeout_hit;
  assign bubble      = FlushW | stall | ~InstrValidM | timeout_hit | (load & misaligned);
  assign StallM      = stall;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    result_d     = result_q;
    write_reg_d  = write_reg_q;
    reg_write_d  = 1'b0;
    retire_cnt_d = retire_cnt_q;
    error_d      = error_q;

    case (state_q)
      S_RUN:  if (stall) state_d = S_WAIT;
      S_WAIT: begin
        if (ReadValidM | FlushW | timeout_hit) state_d = S_RUN;
        else wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      default: state_d = S_RUN;
    endcase

    if (!bubble) begin
      result_d     = load ? load_data : ALUOutM;
      write_reg_d  = WriteRegM;
      reg_write_d  = RegWriteM & (WriteRegM != 5'd0);
      retire_cnt_d = retire_cnt_q + 32'd1;
    end

    if (!FlushW && ((load && misaligned) || timeout_hit)) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      wait_cnt_q   <= '0;
      result_q     <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      retire_cnt_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      result_q     <= result_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      retire_cnt_q <= retire_cnt_d;
      error_q      <= error_d;
    end
  end

  assign ResultW      = result_q;
  assign WriteRegW    = write_reg_q;
  assign RegWriteW    = reg_write_q;
  assign RetireCountW = retire_cnt_q;
  assign ErrorW       = error_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU/load writeback, load stalls, timeout, faults, flush, reset.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InstrValidM, RegWriteM, MemToRegM;
  logic [2:0]  LoadTypeM;
  logic [31:0] ALUOutM;
  logic [4:0]  WriteRegM;
  logic [31:0] ReadDataM;
  logic        ReadValidM, FlushW;
  logic        StallM;
  logic [31:0] ResultW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW;
  logic [31:0] RetireCountW;
  logic        ErrorW;

  int total = 0;
  int bad   = 0;

  writeback_stage #(.LOAD_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .InstrValidM(InstrValidM), .RegWriteM(RegWriteM),
    .MemToRegM(MemToRegM), .LoadTypeM(LoadTypeM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
    .ReadDataM(ReadDataM), .ReadValidM(ReadValidM), .FlushW(FlushW), .StallM(StallM),
    .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .RetireCountW(RetireCountW), .ErrorW(ErrorW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic rw, input logic mtr, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [4:0] wr, input logic [31:0] rd,
                       input logic rv, input logic fl);
    InstrValidM = iv; RegWriteM = rw; MemToRegM = mtr; LoadTypeM = lt;
    ALUOutM = alu; WriteRegM = wr; ReadDataM = rd; ReadValidM = rv; FlushW = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"},  32'(StallM), 32'd0);
    chk({tag, "_result"}, ResultW, 32'd0);
    chk({tag, "_wreg"},   32'(WriteRegW), 32'd0);
    chk({tag, "_regwr"},  32'(RegWriteW), 32'd0);
    chk({tag, "_retire"}, RetireCountW, 32'd0);
    chk({tag, "_error"},  32'(ErrorW), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 3'b000, 32'd0, 5'd0, 32'd0, 0, 0);
    #12;
    chk_reset_outputs("rst0");
    rst_n = 1'b1;

    // ALU writeback
    drive(1, 1, 0, 3'b000, 32'h1234, 5'd8, 32'd0, 0, 0);
    #1 chk("alu_stall", 32'(StallM), 32'd0);
    tick();
    chk("alu_regwr",  32'(RegWriteW), 32'd1);
    chk("alu_wreg",   32'(WriteRegW), 32'd8);
    chk("alu_result", ResultW, 32'h1234);
    chk("alu_retire", RetireCountW, 32'd1);

    // Load extraction with data valid immediately
    drive(1, 1, 1, 3'b001, 32'h100, 5'd9, 32'h80FF7F01, 1, 0);
    tick(); chk("lb_result", ResultW, 32'hFFFFFF80);
    chk("lb_regwr", 32'(RegWriteW), 32'd1);
    drive(1, 1, 1, 3'b101, 32'h100, 5'd9, 32'h80FF7F01, 1, 0);
    tick(); chk("lbu_result", ResultW, 32'h00000080);
    drive(1, 1, 1, 3'b010, 32'h102, 5'd9, 32'h80FF7F01, 1, 0);
    tick(); chk("lh_result", ResultW, 32'h00007F01);
    drive(1, 1, 1, 3'b110, 32'h100, 5'd9, 32'h80FF7F01, 1, 0);
    tick(); chk("lhu_result", ResultW, 32'h000080FF);
    chk("ld_retire", RetireCountW, 32'd5);

    // lw waiting three cycles for data
    drive(1, 1, 1, 3'b000, 32'h200, 5'd10, 32'hDEADBEEF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("lw_wait_stall", 32'(StallM), 32'd1);
      tick();
      chk("lw_wait_regwr", 32'(RegWriteW), 32'd0);
    end
    chk("lw_wait_retire", RetireCountW, 32'd5);
    ReadValidM = 1'b1;
    #1 chk("lw_valid_stall", 32'(StallM), 32'd0);
    tick();
    chk("lw_result", ResultW, 32'hDEADBEEF);
    chk("lw_wreg",   32'(WriteRegW), 32'd10);
    chk("lw_regwr",  32'(RegWriteW), 32'd1);
    chk("lw_retire", RetireCountW, 32'd6);

    drive(0, 0, 0, 3'b000, 32'd0, 5'd0, 32'd0, 0, 0);
    tick();
    chk("idle_retire", RetireCountW, 32'd6);

    // Load timeout: 16 stall cycles, then the load is dropped
    drive(1, 1, 1, 3'b000, 32'h300, 5'd11, 32'h55AA55AA, 0, 0);
    for (int i = 0; i < 16; i++) begin
      #1 chk("to_stall", 32'(StallM), 32'd1);
      tick();
    end
    chk("to_err_before", 32'(ErrorW), 32'd0);
    #1 chk("to_stall_drop", 32'(StallM), 32'd0);
    tick();
    chk("to_error",  32'(ErrorW), 32'd1);
    chk("to_regwr",  32'(RegWriteW), 32'd0);
    chk("to_retire", RetireCountW, 32'd6);
    chk("to_result", ResultW, 32'hDEADBEEF);
    drive(0, 0, 0, 3'b000, 32'd0, 5'd0, 32'd0, 0, 0);
    tick();

    rst_n = 1'b0;
    #2;
    chk_reset_outputs("rst1");
    rst_n = 1'b1;

    // Misaligned lw: fault, no write, no stall
    drive(1, 1, 1, 3'b000, 32'h1002, 5'd12, 32'h11112222, 0, 0);
    #1 chk("mis_stall", 32'(StallM), 32'd0);
    tick();
    chk("mis_error",  32'(ErrorW), 32'd1);
    chk("mis_regwr",  32'(RegWriteW), 32'd0);
    chk("mis_retire", RetireCountW, 32'd0);

    // Write to $0 retires but does not write
    drive(1, 1, 0, 3'b000, 32'h5678, 5'd0, 32'd0, 0, 0);
    tick();
    chk("r0_regwr",  32'(RegWriteW), 32'd0);
    chk("r0_result", ResultW, 32'h5678);
    chk("r0_retire", RetireCountW, 32'd1);

    // Flush during a load wait beats a same-cycle ReadValidM
    drive(1, 1, 1, 3'b000, 32'h400, 5'd13, 32'hCAFEF00D, 0, 0);
    #1 chk("fl_stall1", 32'(StallM), 32'd1);
    tick();
    ReadValidM = 1'b1;
    FlushW = 1'b1;
    #1 chk("fl_stall2", 32'(StallM), 32'd0);
    tick();
    chk("fl_regwr",  32'(RegWriteW), 32'd0);
    chk("fl_result", ResultW, 32'h5678);
    chk("fl_retire", RetireCountW, 32'd1);

    // FSM back in RUN: a new load with data valid completes at once
    drive(1, 1, 1, 3'b000, 32'h404, 5'd14, 32'h0BADF00D, 1, 0);
    #1 chk("fl_run_stall", 32'(StallM), 32'd0);
    tick();
    chk("fl_run_result", ResultW, 32'h0BADF00D);
    chk("fl_run_retire", RetireCountW, 32'd2);

    // Reset asserted mid-WAIT clears everything immediately
    drive(1, 1, 1, 3'b000, 32'h500, 5'd15, 32'h12345678, 0, 0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_wait");
    #3 rst_n = 1'b1;
    ReadValidM = 1'b1;
    tick();
    chk("post_rst_result", ResultW, 32'h12345678);
    chk("post_rst_retire", RetireCountW, 32'd1);
    chk("post_rst_error",  32'(ErrorW), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
